// File: rtl/mul3_pipe_hs.sv
// Four-stage pipelined a*b*c multiplier with valid/ready handshake and sideband tag.
// Optional rounding right shift and saturation to OW bits in the output stage.
module mul3_pipe_hs #(
    parameter int AW     = 18,
    parameter int BW     = 10,
    parameter int CW     = 10,
    parameter int OW     = 38,
    parameter int TW     = 8,
    parameter int SIGNED = 0,
    parameter int SHIFT  = 0,
    parameter int ROUND  = 0,
    parameter int SAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [CW-1:0] c,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [TW-1:0] out_tag,
    output logic          busy
);

    localparam int PW  = AW + BW + CW;
    localparam int BCW = BW + CW;
    localparam int LW  = PW + 2;
    localparam int XW  = (OW > LW) ? OW : LW;
    localparam bit NEED_SAT = (SAT != 0) && (OW < PW - SHIFT + 1);

    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam int OSH = (OW < LW) ? OW : LW - 1;
    localparam logic signed [LW-1:0] ONE_L   = LW'(1);
    localparam logic signed [LW-1:0] RND_ADD = ((ROUND != 0) && (SHIFT > 0)) ? (ONE_L <<< RSH) : '0;
    localparam logic signed [LW-1:0] SAT_MAX = (SIGNED != 0) ? ((ONE_L <<< (OSH - 1)) - ONE_L)
                                                             : ((ONE_L <<< OSH) - ONE_L);
    localparam logic signed [LW-1:0] SAT_MIN = (SIGNED != 0) ? -(ONE_L <<< (OSH - 1)) : '0;

    generate
        if (SHIFT < 0 || SHIFT >= PW || OW < 1) begin : g_param_check
            $fatal(1, "mul3_pipe_hs: illegal SHIFT or OW parameter");
        end
    endgenerate

    logic           v1_q, v2_q, v3_q, v4_q;
    logic [AW-1:0]  a1_q, a2_q;
    logic [BCW-1:0] bc1_q, bc2_q;
    logic [PW-1:0]  p3_q;
    logic [OW-1:0]  data4_q;
    logic [TW-1:0]  tag1_q, tag2_q, tag3_q, tag4_q;

    logic en;

    assign en        = !(v4_q && !out_ready);
    assign in_ready  = en || !rst_n;
    assign out_valid = v4_q;
    assign out_data  = data4_q;
    assign out_tag   = tag4_q;
    assign busy      = v1_q || v2_q || v3_q || v4_q;

    // Operands carry one extra bit so a single signed multiply covers both modes.
    logic signed [BW:0]     b_x;
    logic signed [CW:0]     c_x;
    logic signed [AW:0]     a2_x;
    logic signed [BCW:0]    bc2_x;
    logic        [BCW-1:0]  bc_d;
    logic        [PW-1:0]   p_d;

    always_comb begin
        b_x   = (SIGNED != 0) ? {b[BW-1], b} : {1'b0, b};
        c_x   = (SIGNED != 0) ? {c[CW-1], c} : {1'b0, c};
        bc_d  = BCW'((BCW + 2)'(b_x) * (BCW + 2)'(c_x));
        a2_x  = (SIGNED != 0) ? {a2_q[AW-1], a2_q} : {1'b0, a2_q};
        bc2_x = (SIGNED != 0) ? {bc2_q[BCW-1], bc2_q} : {1'b0, bc2_q};
        p_d   = PW'(LW'(a2_x) * LW'(bc2_x));
    end

    // Two extra bits: a guard for the rounding add and a sign for unsigned data.
    logic signed [LW-1:0] p_ext, p_rnd, p_sh, p_sat;
    logic        [OW-1:0] res_d;

    always_comb begin
        p_ext = (SIGNED != 0) ? {{2{p3_q[PW-1]}}, p3_q} : {2'b00, p3_q};
        p_rnd = p_ext + RND_ADD;
        p_sh  = p_rnd >>> SHIFT;
        p_sat = p_sh;
        if (NEED_SAT) begin
            if (p_sh > SAT_MAX) begin
                p_sat = SAT_MAX;
            end else if (p_sh < SAT_MIN) begin
                p_sat = SAT_MIN;
            end
        end
        res_d = OW'(XW'(p_sat));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            v4_q    <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
            bc1_q   <= '0;
            bc2_q   <= '0;
            p3_q    <= '0;
            data4_q <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            tag4_q  <= '0;
        end else if (en) begin
            v1_q    <= in_valid;
            a1_q    <= a;
            bc1_q   <= bc_d;
            tag1_q  <= in_tag;
            v2_q    <= v1_q;
            a2_q    <= a1_q;
            bc2_q   <= bc1_q;
            tag2_q  <= tag1_q;
            v3_q    <= v2_q;
            p3_q    <= p_d;
            tag3_q  <= tag2_q;
            v4_q    <= v3_q;
            data4_q <= res_d;
            tag4_q  <= tag3_q;
        end
    end

endmodule

// File: tb/tb_mul3_pipe_hs.sv
// Bench for mul3_pipe_hs: seven parameter variants share one input stream.
// A queue of expected results is filled on accept and drained on output handshakes.
module tb_mul3_pipe_hs;

    typedef struct packed {
        logic [7:0]       tag;
        logic [6:0][63:0] exp;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [17:0] a;
    logic [9:0]  b;
    logic [9:0]  c;
    logic [7:0]  in_tag;

    logic        rdy [7];
    logic        ovl [7];
    logic        bsy [7];
    logic [7:0]  otg [7];
    logic [37:0] d0, d1, d2, d3;
    logic [15:0] d4, d5, d6;
    logic [63:0] dobs [7];

    int checks = 0;
    int errors = 0;
    entry_t sb[$];
    logic [6:0]       ov_en = '0;
    logic [6:0][63:0] ov_val = '0;

    assign dobs[0] = {26'b0, d0};
    assign dobs[1] = {26'b0, d1};
    assign dobs[2] = {26'b0, d2};
    assign dobs[3] = {26'b0, d3};
    assign dobs[4] = {48'b0, d4};
    assign dobs[5] = {48'b0, d5};
    assign dobs[6] = {48'b0, d6};

    mul3_pipe_hs u_def (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .c(c), .in_tag(in_tag), .out_valid(ovl[0]), .out_ready(out_ready),
        .out_data(d0), .out_tag(otg[0]), .busy(bsy[0]));
    mul3_pipe_hs #(.SIGNED(1)) u_s38 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .c(c), .in_tag(in_tag), .out_valid(ovl[1]), .out_ready(out_ready),
        .out_data(d1), .out_tag(otg[1]), .busy(bsy[1]));
    mul3_pipe_hs #(.SHIFT(4), .ROUND(1)) u_sh4u (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a), .b(b), .c(c), .in_tag(in_tag), .out_valid(ovl[2]), .out_ready(out_ready),
        .out_data(d2), .out_tag(otg[2]), .busy(bsy[2]));
    mul3_pipe_hs #(.SHIFT(4), .ROUND(1), .SIGNED(1)) u_sh4s (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy[3]), .a(a), .b(b), .c(c), .in_tag(in_tag), .out_valid(ovl[3]), .out_ready(out_ready),
        .out_data(d3), .out_tag(otg[3]), .busy(bsy[3]));
    mul3_pipe_hs #(.OW(16), .SAT(1)) u_o16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[4]),
        .a(a), .b(b), .c(c), .in_tag(in_tag), .out_valid(ovl[4]), .out_ready(out_ready),
        .out_data(d4), .out_tag(otg[4]), .busy(bsy[4]));
    mul3_pipe_hs #(.OW(16), .SAT(0)) u_o16t (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[5]),
        .a(a), .b(b), .c(c), .in_tag(in_tag), .out_valid(ovl[5]), .out_ready(out_ready),
        .out_data(d5), .out_tag(otg[5]), .busy(bsy[5]));
    mul3_pipe_hs #(.OW(16), .SAT(1), .SIGNED(1)) u_o16s (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(rdy[6]), .a(a), .b(b), .c(c), .in_tag(in_tag), .out_valid(ovl[6]), .out_ready(out_ready),
        .out_data(d6), .out_tag(otg[6]), .busy(bsy[6]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Reference: full-precision integer product, round, arithmetic shift, clip, mask to ow bits.
    function automatic logic [63:0] model(input int sg, input int sh, input int rnd, input int sat,
                                          input int ow, input logic [17:0] av, input logic [9:0] bv,
                                          input logic [9:0] cv);
        longint pa, pb, pc, p, hi, lo;
        if (sg != 0) begin
            pa = longint'($signed(av));
            pb = longint'($signed(bv));
            pc = longint'($signed(cv));
        end else begin
            pa = longint'(av);
            pb = longint'(bv);
            pc = longint'(cv);
        end
        p = pa * pb * pc;
        if (rnd != 0 && sh > 0) p = p + (longint'(1) <<< (sh - 1));
        p = p >>> sh;
        if (sat != 0) begin
            if (sg != 0) begin
                hi = (longint'(1) <<< (ow - 1)) - 1;
                lo = -hi - 1;
            end else begin
                hi = (longint'(1) <<< ow) - 1;
                lo = 0;
            end
            if (p > hi) p = hi;
            else if (p < lo) p = lo;
        end
        return 64'(p) & ((64'd1 << ow) - 64'd1);
    endfunction

    always @(negedge clk) begin
        entry_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (ovl[0] && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL sb_has_item: output with empty scoreboard");
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    for (int k = 0; k < 7; k++) begin
                        checks++;
                        if (dobs[k] !== e.exp[k]) begin
                            errors++;
                            $error("FAIL data_inst%0d_tag%0h observed=%0h expected=%0h", k, e.tag, dobs[k], e.exp[k]);
                        end
                        checks++;
                        if (otg[k] !== e.tag) begin
                            errors++;
                            $error("FAIL tag_inst%0d observed=%0h expected=%0h", k, otg[k], e.tag);
                        end
                        checks++;
                        if (ovl[k] !== 1'b1) begin
                            errors++;
                            $error("FAIL valid_inst%0d observed=%0h expected=1", k, ovl[k]);
                        end
                    end
                end
            end
            if (in_valid && rdy[0]) begin
                e.tag    = in_tag;
                e.exp[0] = model(0, 0, 0, 1, 38, a, b, c);
                e.exp[1] = model(1, 0, 0, 1, 38, a, b, c);
                e.exp[2] = model(0, 4, 1, 1, 38, a, b, c);
                e.exp[3] = model(1, 4, 1, 1, 38, a, b, c);
                e.exp[4] = model(0, 0, 0, 1, 16, a, b, c);
                e.exp[5] = model(0, 0, 0, 0, 16, a, b, c);
                e.exp[6] = model(1, 0, 0, 1, 16, a, b, c);
                for (int k = 0; k < 7; k++) if (ov_en[k]) e.exp[k] = ov_val[k];
                ov_en = '0;
                sb.push_back(e);
            end
        end
    end

    task automatic ov(input int k, input logic [63:0] v);
        ov_en[k]  = 1'b1;
        ov_val[k] = v;
    endtask

    task automatic send(input int av, input int bv, input int cv, input int tg);
        bit ok;
        ok       = 1'b0;
        a        = 18'(av);
        b        = 10'(bv);
        c        = 10'(cv);
        in_tag   = 8'(tg);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = rdy[0];
            @(posedge clk);
            #1;
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL send_accepted tag=%0h", tg);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [63:0] held_d;
        logic [7:0]  held_t;
        int          n_sent;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        c         = '0;
        in_tag    = '0;

        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $error("FAIL in_ready_in_reset observed=%0h", rdy[0]); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $error("FAIL rst_in_ready observed=%0h", rdy[0]); end
        checks++;
        if (ovl[0] !== 1'b0) begin errors++; $error("FAIL rst_out_valid observed=%0h", ovl[0]); end
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $error("FAIL rst_busy observed=%0h", bsy[0]); end
        checks++;
        if (dobs[0] !== 64'd0) begin errors++; $error("FAIL rst_out_data observed=%0h", dobs[0]); end
        checks++;
        if (otg[0] !== 8'h00) begin errors++; $error("FAIL rst_out_tag observed=%0h", otg[0]); end
        @(posedge clk);
        #1;

        // Latency: accepted in cycle 0, visible in cycle 4, pipeline empty in cycle 5.
        send(3, 5, 7, 'h11);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (ovl[0] !== 1'b0) begin errors++; $error("FAIL lat_no_valid_c%0d observed=%0h", k, ovl[0]); end
            end else begin
                checks++;
                if (ovl[0] !== 1'b1) begin errors++; $error("FAIL lat_valid_c4 observed=%0h", ovl[0]); end
                checks++;
                if (dobs[0] !== 64'd105) begin errors++; $error("FAIL lat_data_c4 observed=%0h", dobs[0]); end
                checks++;
                if (otg[0] !== 8'h11) begin errors++; $error("FAIL lat_tag_c4 observed=%0h", otg[0]); end
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $error("FAIL lat_busy_c5 observed=%0h", bsy[0]); end
        @(posedge clk);
        #1;

        // Directed corner values, back to back.
        ov(0, 64'd274340251647);  send(262143, 1023, 1023, 'h21);
        ov(1, 64'd24);            send(-2, 3, -4, 'h22);
        ov(1, 64'd34292629504);   send(-131072, 511, -512, 'h23);
        ov(2, 64'd2);             send(1, 1, 24, 'h24);
        ov(2, 64'd1);             send(1, 1, 23, 'h25);
        ov(3, 64'h3F_FFFF_FFFF);  send(-1, 1, 24, 'h26);
        ov(3, 64'h3F_FFFF_FFFE);  send(-1, 1, 25, 'h27);
        ov(4, 64'd65535); ov(5, 64'd16960); send(1000, 1000, 1, 'h28);
        ov(6, 64'h8000);          send(-1000, 100, 10, 'h29);
        idle(8);

        for (int i = 0; i < 10; i++) begin
            send(int'($urandom_range(0, 262143)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 1023)), 'h40 + i);
        end
        idle(8);

        // Backpressure: out_ready low in cycles 5..9 while six items stream in.
        n_sent = 0;
        held_d = '0;
        held_t = '0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 9);
            if (n_sent < 6) begin
                a        = 18'($urandom_range(0, 262143));
                b        = 10'($urandom_range(0, 1023));
                c        = 10'($urandom_range(0, 1023));
                in_tag   = 8'('h50 + n_sent);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && rdy[0]) n_sent++;
            if (cyc >= 5 && cyc <= 9) begin
                checks++;
                if (rdy[0] !== 1'b0) begin errors++; $error("FAIL stall_in_ready_c%0d observed=%0h", cyc, rdy[0]); end
                checks++;
                if (ovl[0] !== 1'b1) begin errors++; $error("FAIL stall_out_valid_c%0d observed=%0h", cyc, ovl[0]); end
                if (cyc == 5) begin
                    held_d = dobs[0];
                    held_t = otg[0];
                end else begin
                    checks++;
                    if (dobs[0] !== held_d) begin
                        errors++;
                        $error("FAIL stall_data_c%0d observed=%0h expected=%0h", cyc, dobs[0], held_d);
                    end
                    checks++;
                    if (otg[0] !== held_t) begin
                        errors++;
                        $error("FAIL stall_tag_c%0d observed=%0h expected=%0h", cyc, otg[0], held_t);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_sent != 6) begin errors++; $error("FAIL bp_all_sent observed=%0d", n_sent); end
        out_ready = 1'b1;
        idle(4);
        checks++;
        if (sb.size() != 0) begin errors++; $error("FAIL bp_sb_drained observed=%0d", sb.size()); end

        // Reset with three items in flight.
        send(11, 12, 13, 'h60);
        send(21, 22, 23, 'h61);
        send(31, 32, 33, 'h62);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ovl[0] !== 1'b0) begin errors++; $error("FAIL flush_out_valid observed=%0h", ovl[0]); end
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $error("FAIL flush_busy observed=%0h", bsy[0]); end
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $error("FAIL flush_in_ready observed=%0h", rdy[0]); end
        checks++;
        if (dobs[0] !== 64'd0) begin errors++; $error("FAIL flush_out_data observed=%0h", dobs[0]); end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (ovl[0] !== 1'b0) begin errors++; $error("FAIL flush_no_stale_c%0d observed=%0h", k, ovl[0]); end
        end
        @(posedge clk);
        #1;

        ov(0, 64'd729);
        send(9, 9, 9, 'h7E);
        idle(8);
        checks++;
        if (sb.size() != 0) begin errors++; $error("FAIL final_sb_empty observed=%0d", sb.size()); end
        checks++;
        if (bsy[0] !== 1'b0) begin errors++; $error("FAIL final_busy observed=%0h", bsy[0]); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
